// File: rtl/pdc_ram_ctl.sv
// Write-port arbiter and clear sequencer for the pdc RAM: zero-sweeps every entry after
// reset or flush, then round-robins the single write port between two requesters.
module pdc_ram_ctl #(
  parameter int AW = 11,
  parameter int DW = 32  // pdc entry width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  output logic                 ready,
  input  logic [1:0]           wr_req,
  input  logic [1:0][AW-1:0]   wr_addr,
  input  logic [1:0][DW-1:0]   wr_data,
  output logic [1:0]           wr_gnt,
  input  logic [2:0][AW-1:0]   rd_addr_in,
  input  logic [2:0]           rd_en_in,
  output logic [2:0]           rd_conflict,
  output logic [2:0][AW-1:0]   ram_read_addr,
  output logic [2:0]           ram_read_clkEn,
  output logic [AW-1:0]        ram_write_addr,
  output logic [DW-1:0]        ram_write_data,
  output logic                 ram_write_wen,
  output logic                 state_dbg
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          ptr;
  logic [2:0]    conf_s1;
  logic [2:0]    conf_next;

  assign state_dbg = (state == RUN);

  // Handshake: a requester raises wr_req[i] and holds it with stable addr/data until the
  // cycle wr_gnt[i] is high; that cycle is the transfer and the RAM commits on the next edge.
  always_comb begin
    wr_gnt = 2'b00;
    if (state == RUN) begin
      case (wr_req)
        2'b01:   wr_gnt = 2'b01;
        2'b10:   wr_gnt = 2'b10;
        2'b11:   wr_gnt = ptr ? 2'b10 : 2'b01;
        default: wr_gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ram_write_wen  = 1'b0;
    ram_write_addr = '0;
    ram_write_data = '0;
    if (state == INIT) begin
      ram_write_wen  = 1'b1;
      ram_write_addr = cnt;
    end else if (wr_gnt[0]) begin
      ram_write_wen  = 1'b1;
      ram_write_addr = wr_addr[0];
      ram_write_data = wr_data[0];
    end else if (wr_gnt[1]) begin
      ram_write_wen  = 1'b1;
      ram_write_addr = wr_addr[1];
      ram_write_data = wr_data[1];
    end
  end

  assign ram_read_addr  = rd_addr_in;
  assign ram_read_clkEn = rd_en_in & {3{ready}};

  // Reads are gated off during the sweep, so sweep writes can never raise a conflict.
  always_comb begin
    conf_next = 3'b000;
    for (int k = 0; k < 3; k++) begin
      conf_next[k] = ram_read_clkEn[k] & ram_write_wen & (rd_addr_in[k] == ram_write_addr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INIT;
      cnt         <= '0;
      ptr         <= 1'b0;
      ready       <= 1'b0;
      conf_s1     <= 3'b000;
      rd_conflict <= 3'b000;
    end else begin
      // Two stages to line up with the RAM's registered address and read data.
      conf_s1     <= conf_next;
      rd_conflict <= conf_s1;

      if (wr_gnt[0]) begin
        ptr <= 1'b1;
      end else if (wr_gnt[1]) begin
        ptr <= 1'b0;
      end

      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdc_ram_ctl.sv
// Directed bench for pdc_ram_ctl: clear sweeps, round-robin arbitration, read conflict
// pipe, flush and mid-sweep reset.
module tb_pdc_ram_ctl;

  localparam int AW = 11;
  localparam int DW = 32;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 ready;
  logic [1:0]           wr_req;
  logic [1:0][AW-1:0]   wr_addr;
  logic [1:0][DW-1:0]   wr_data;
  logic [1:0]           wr_gnt;
  logic [2:0][AW-1:0]   rd_addr_in;
  logic [2:0]           rd_en_in;
  logic [2:0]           rd_conflict;
  logic [2:0][AW-1:0]   ram_read_addr;
  logic [2:0]           ram_read_clkEn;
  logic [AW-1:0]        ram_write_addr;
  logic [DW-1:0]        ram_write_data;
  logic                 ram_write_wen;
  logic                 state_dbg;

  int vectors;
  int miscompares;

  pdc_ram_ctl #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .ready          (ready),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_gnt         (wr_gnt),
    .rd_addr_in     (rd_addr_in),
    .rd_en_in       (rd_en_in),
    .rd_conflict    (rd_conflict),
    .ram_read_addr  (ram_read_addr),
    .ram_read_clkEn (ram_read_clkEn),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_write_wen  (ram_write_wen),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] pk(input logic [2:0] ce, input logic [2:0] cf,
                                     input logic r, input logic [1:0] g, input logic w,
                                     input logic [10:0] a, input logic [31:0] d);
    return {11'd0, ce, cf, r, g, w, a, d};
  endfunction

  function automatic logic [63:0] obs();
    return pk(ram_read_clkEn, rd_conflict, ready, wr_gnt, ram_write_wen,
              ram_write_addr, ram_write_data);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks n consecutive sweep writes starting at address 0; optional flush pulse at flush_at.
  task automatic sweep(input int n, input int flush_at);
    logic [10:0] a;
    for (int i = 0; i < n; i++) begin
      flush = (i == flush_at);
      a = i[10:0];
      #1;
      chk("sweep", obs(), pk(3'b000, 3'b000, 1'b0, 2'b00, 1'b1, a, 32'h0));
      if (i != n - 1) step();
    end
    flush = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    flush       = 1'b0;
    wr_req      = 2'b11;
    wr_addr[0]  = 11'h010;
    wr_addr[1]  = 11'h020;
    wr_data[0]  = 32'hA0A0_0001;
    wr_data[1]  = 32'hB0B0_0002;
    rd_addr_in  = {11'h300, 11'h200, 11'h100};
    rd_en_in    = 3'b111;

    repeat (3) step();
    chk("reset_outs", obs(), pk(3'b000, 3'b000, 1'b0, 2'b00, 1'b1, 11'h000, 32'h0));
    chk("reset_state", {63'd0, state_dbg}, 64'd0);

    @(negedge clk);
    rst = 1'b1;
    sweep(2048, -1);

    // first RUN cycle: both requesting, ptr=0
    step();
    chk("rr_0", obs(), pk(3'b111, 3'b000, 1'b1, 2'b01, 1'b1, 11'h010, 32'hA0A0_0001));
    chk("run_state", {63'd0, state_dbg}, 64'd1);
    chk("rd_pass", {31'd0, ram_read_addr}, {31'd0, 11'h300, 11'h200, 11'h100});
    step();
    chk("rr_1", obs(), pk(3'b111, 3'b000, 1'b1, 2'b10, 1'b1, 11'h020, 32'hB0B0_0002));
    step();
    chk("rr_2", obs(), pk(3'b111, 3'b000, 1'b1, 2'b01, 1'b1, 11'h010, 32'hA0A0_0001));
    step();
    chk("rr_3", obs(), pk(3'b111, 3'b000, 1'b1, 2'b10, 1'b1, 11'h020, 32'hB0B0_0002));

    step();
    wr_req     = 2'b01;
    wr_addr[0] = 11'h123;
    wr_data[0] = 32'hDEAD_BEEF;
    #1;
    chk("single_0", obs(), pk(3'b111, 3'b000, 1'b1, 2'b01, 1'b1, 11'h123, 32'hDEAD_BEEF));

    step();
    wr_req     = 2'b10;
    wr_addr[1] = 11'h2A0;
    wr_data[1] = 32'hCAFE_0001;
    #1;
    chk("single_1", obs(), pk(3'b111, 3'b000, 1'b1, 2'b10, 1'b1, 11'h2A0, 32'hCAFE_0001));

    step();
    wr_req = 2'b00;
    #1;
    chk("idle", obs(), pk(3'b111, 3'b000, 1'b1, 2'b00, 1'b0, 11'h000, 32'h0));

    // conflict: port 1 reads 0x055 while requester 0 writes 0x055
    step();
    wr_req        = 2'b01;
    wr_addr[0]    = 11'h055;
    wr_data[0]    = 32'h5555_0055;
    rd_addr_in[1] = 11'h055;
    #1;
    chk("conf_n", obs(), pk(3'b111, 3'b000, 1'b1, 2'b01, 1'b1, 11'h055, 32'h5555_0055));
    step();
    wr_req = 2'b00;
    #1;
    chk("conf_n1", obs(), pk(3'b111, 3'b000, 1'b1, 2'b00, 1'b0, 11'h000, 32'h0));
    step();
    chk("conf_n2", obs(), pk(3'b111, 3'b010, 1'b1, 2'b00, 1'b0, 11'h000, 32'h0));
    step();
    chk("conf_n3", obs(), pk(3'b111, 3'b000, 1'b1, 2'b00, 1'b0, 11'h000, 32'h0));

    // near-miss address: no conflict
    step();
    wr_req     = 2'b01;
    wr_addr[0] = 11'h056;
    #1;
    chk("noconf_n", obs(), pk(3'b111, 3'b000, 1'b1, 2'b01, 1'b1, 11'h056, 32'h5555_0055));
    step();
    wr_req = 2'b00;
    #1;
    chk("noconf_n1", obs(), pk(3'b111, 3'b000, 1'b1, 2'b00, 1'b0, 11'h000, 32'h0));
    step();
    chk("noconf_n2", obs(), pk(3'b111, 3'b000, 1'b1, 2'b00, 1'b0, 11'h000, 32'h0));

    // flush with a concurrent grant; flush mid-sweep must be ignored
    step();
    wr_req     = 2'b10;
    wr_addr[1] = 11'h3AA;
    wr_data[1] = 32'h3AA0_F00D;
    flush      = 1'b1;
    #1;
    chk("flush_gnt", obs(), pk(3'b111, 3'b000, 1'b1, 2'b10, 1'b1, 11'h3AA, 32'h3AA0_F00D));
    step();
    flush  = 1'b0;
    wr_req = 2'b00;
    sweep(2048, 100);
    step();
    chk("ready_2", obs(), pk(3'b111, 3'b000, 1'b1, 2'b00, 1'b0, 11'h000, 32'h0));

    // reset at sweep count 700
    flush = 1'b1;
    step();
    flush = 1'b0;
    sweep(701, -1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst", obs(), pk(3'b000, 3'b000, 1'b0, 2'b00, 1'b1, 11'h000, 32'h0));
    chk("async_rst_state", {63'd0, state_dbg}, 64'd0);
    repeat (2) step();
    @(negedge clk);
    rst = 1'b1;
    sweep(2048, -1);
    step();
    chk("ready_3", obs(), pk(3'b111, 3'b000, 1'b1, 2'b00, 1'b0, 11'h000, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
